bot_dispatch_merge: RTL and testbench
=====================================

BOT_DISPATCH_MERGE -- requirements
Module: bot_dispatch_merge

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of compute cores served (legal 1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 128, bot width.
REQ-003 SHALL have parameter EXTRA_WIDTH, default 16, tag width (bot index plus 3-bit permutation sub-address).
REQ-004 SHALL have parameter COUNT_WIDTH, default 6, per-result count width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 32, input buffer entries (power of 2).
REQ-006 SHALL have parameter READY_THRESHOLD, default 20, maximum occupancy at which bursts are accepted.
REQ-007 SHALL have ports:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  bot write strobe
- in_data  in  DATA_WIDTH  bot
- in_extra  in  EXTRA_WIDTH  bot tag
- ready_for_burst  out  1  upstream may start a burst
- fifo_used  out  log2(FIFO_DEPTH)+1  occupancy
- core_request  in  NUM_CORES  one-cycle per-core request pulses
- core_start  out  NUM_CORES  one-hot delivery strobe
- core_data  out  DATA_WIDTH  shared delivery bus
- core_extra  out  EXTRA_WIDTH  shared delivery tag
- core_done  in  NUM_CORES  per-core result strobes
- core_count  in  NUM_CORES*COUNT_WIDTH  packed counts, core i at slice i
- core_tag  in  NUM_CORES*EXTRA_WIDTH  packed result tags
- res_valid  out  1  merged result strobe
- res_count  out  COUNT_WIDTH  merged count
- res_extra  out  EXTRA_WIDTH  merged tag
- in_overflow  out  1  sticky: write while full
- res_overflow  out  1  sticky: result lost

Function
REQ-008 SHALL push {in_data,in_extra} into the FIFO on every cycle with in_valid=1 and FIFO not full; a write while full SHALL be dropped and SHALL set in_overflow.
REQ-009 SHALL register ready_for_burst = (fifo_used <= READY_THRESHOLD), one cycle behind occupancy.
REQ-010 SHALL keep a 2-bit saturating pending-request counter per core: +1 on core_request, -1 on dispatch, unchanged on both in the same cycle, and a request at 3 SHALL be ignored.
REQ-011 SHALL dispatch at most one bot per cycle, only when FIFO is non-empty and some core has pending>0, granting round-robin starting at the core after the last grant (the pointer starts at core 0).
REQ-012 SHALL drive core_start (one-hot), core_data and core_extra registered on the cycle after the pop; core_data and core_extra SHALL hold their last value while core_start=0.
REQ-013 SHALL allow a push and a pop in the same cycle, leaving occupancy unchanged (this includes the full case, where the pop frees the slot first).
REQ-014 SHALL capture core_done for core i into a per-core holding register (count, tag).
REQ-015 When a holding register is valid and is not drained in that cycle, a new core_done SHALL be dropped, the old entry SHALL be kept, and res_overflow SHALL be set.
REQ-016 SHALL drain one valid holding register per cycle by round-robin, and SHALL drive res_valid, res_count and res_extra registered; the minimum latency from core_done to res_valid SHALL be 2 cycles.
REQ-017 A drain and a new core_done on the same core in the same cycle SHALL accept the new entry.
REQ-018 With NUM_CORES=1, the arbiters SHALL degenerate to pass-through with the same latencies.

Reset
REQ-019 rst_n low SHALL asynchronously clear the FIFO, pending counters, holding registers, round-robin pointers and sticky flags, and SHALL drive all outputs to 0.
REQ-020 ready_for_burst SHALL rise at the first clk edge after rst_n is released; in-flight bots and results at reset SHALL be discarded.

Verification
REQ-021 Write 3 bots, then pulse core_request[2] -> core_start=4'b0100 one cycle after the pop, with the first bot's data and tag; fifo_used goes 3 -> 2.
REQ-022 Pulse core_request on all 4 cores in the same cycle with 4 bots buffered -> deliveries to cores 0,1,2,3 on consecutive cycles, exactly one core_start bit per cycle.
REQ-023 Write 33 bots with no requests -> fifo_used=32, in_overflow=1, ready_for_burst=0; after 12 pops -> ready_for_burst=1.
REQ-024 Pulse core_done on cores 0 and 3 in the same cycle with counts 5 and 9 -> res_valid on 2 consecutive cycles, count 5 then 9, tags matching.
REQ-025 Pulse core_done[1] twice within 1 cycle while the arbiter is serving other cores -> res_overflow=1 and the first entry is preserved.
REQ-026 Assert rst_n low mid-burst -> all outputs 0 immediately; after release, fifo_used=0 and ready_for_burst=1 one edge later.

Source files
------------

// File: rtl/bot_dispatch_merge.sv
// bot_dispatch_merge: buffers incoming bots in a FIFO and hands them to requesting cores
// round-robin, then merges per-core results back into one registered result stream.
// Ports: clk/rst_n (async active-low); in_valid/in_data/in_extra bot writes;
// ready_for_burst/fifo_used occupancy status; core_request/core_start/core_data/core_extra
// dispatch; core_done/core_count/core_tag per-core results; res_valid/res_count/res_extra
// merged results; in_overflow/res_overflow sticky loss flags.
module bot_dispatch_merge #(
    parameter int NUM_CORES       = 4,
    parameter int DATA_WIDTH      = 128,
    parameter int EXTRA_WIDTH     = 16,
    parameter int COUNT_WIDTH     = 6,
    parameter int FIFO_DEPTH      = 32,
    parameter int READY_THRESHOLD = 20
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic [EXTRA_WIDTH-1:0]             in_extra,
    output logic                               ready_for_burst,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_used,
    input  logic [NUM_CORES-1:0]               core_request,
    output logic [NUM_CORES-1:0]               core_start,
    output logic [DATA_WIDTH-1:0]              core_data,
    output logic [EXTRA_WIDTH-1:0]             core_extra,
    input  logic [NUM_CORES-1:0]               core_done,
    input  logic [NUM_CORES*COUNT_WIDTH-1:0]   core_count,
    input  logic [NUM_CORES*EXTRA_WIDTH-1:0]   core_tag,
    output logic                               res_valid,
    output logic [COUNT_WIDTH-1:0]             res_count,
    output logic [EXTRA_WIDTH-1:0]             res_extra,
    output logic                               in_overflow,
    output logic                               res_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    localparam int FW = DATA_WIDTH + EXTRA_WIDTH;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] THR  = (AW+1)'(READY_THRESHOLD);
    logic [FW-1:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wp, r_rp;
    logic [AW:0]            r_used;
    logic [1:0]             r_pend [NUM_CORES];
    logic [IW-1:0]          r_rr, r_res_rr;
    logic [NUM_CORES-1:0]   r_hv;
    logic [COUNT_WIDTH-1:0] r_hc [NUM_CORES];
    logic [EXTRA_WIDTH-1:0] r_ht [NUM_CORES];
    logic [NUM_CORES-1:0]   w_pend_nz, w_req, w_dsp, w_drained;
    logic [IW-1:0]          w_gnt, w_drn;
    logic                   w_gnt_ok, w_drn_ok, w_pop, w_push;
    // First requester at or after start, wrapping; returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [NUM_CORES-1:0] req, input logic [IW-1:0] start);
        logic [IW:0] pick;
        int idx;
        pick = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= NUM_CORES) idx -= NUM_CORES;
            if (req[idx]) pick = {1'b1, IW'(idx)};
        end
        return pick;
    endfunction
    assign fifo_used = r_used;
    assign {w_gnt_ok, w_gnt} = rr_pick(w_pend_nz, r_rr);
    assign {w_drn_ok, w_drn} = rr_pick(r_hv, r_res_rr);
    assign w_pop  = w_gnt_ok && r_used != '0;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
    assign w_push = in_valid && (r_used != FULL || w_pop);
    always_comb begin
        w_pend_nz = '0;
        for (int i = 0; i < NUM_CORES; i++) w_pend_nz[i] = r_pend[i] != 2'd0;
    end
    always_comb begin
        w_req     = '0;
        w_dsp     = '0;
        w_drained = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_req[i]     = core_request[i] && r_pend[i] != 2'd3;
            w_dsp[i]     = w_pop && int'(w_gnt) == i;
            w_drained[i] = w_drn_ok && int'(w_drn) == i;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {in_data, in_extra};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp            <= '0;
            r_rp            <= '0;
            r_used          <= '0;
            r_rr            <= '0;
            in_overflow     <= 1'b0;
            ready_for_burst <= 1'b0;
            core_start      <= '0;
            core_data       <= '0;
            core_extra      <= '0;
            for (int i = 0; i < NUM_CORES; i++) r_pend[i] <= 2'd0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_used          <= r_used + (AW+1)'(w_push) - (AW+1)'(w_pop);
            ready_for_burst <= r_used <= THR;
            if (in_valid && !w_push) in_overflow <= 1'b1;
            core_start <= w_pop ? NUM_CORES'(1) << w_gnt : '0;
            if (w_pop) begin
                {core_data, core_extra} <= r_mem[r_rp];
                r_rr <= int'(w_gnt) == NUM_CORES - 1 ? '0 : w_gnt + 1'b1;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_req[i] && !w_dsp[i]) r_pend[i] <= r_pend[i] + 2'd1;
                else if (!w_req[i] && w_dsp[i]) r_pend[i] <= r_pend[i] - 2'd1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hv         <= '0;
            r_res_rr     <= '0;
            res_valid    <= 1'b0;
            res_count    <= '0;
            res_extra    <= '0;
            res_overflow <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_hc[i] <= '0;
                r_ht[i] <= '0;
            end
        end else begin
            res_valid <= w_drn_ok;
            if (w_drn_ok) begin
                res_count <= r_hc[w_drn];
                res_extra <= r_ht[w_drn];
                r_res_rr  <= int'(w_drn) == NUM_CORES - 1 ? '0 : w_drn + 1'b1;
            end
            if (|(core_done & r_hv & ~w_drained)) res_overflow <= 1'b1;
            // A slot being drained this cycle can take a new result at the same edge.
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_done[i] && (!r_hv[i] || w_drained[i])) begin
                    r_hv[i] <= 1'b1;
                    r_hc[i] <= core_count[i*COUNT_WIDTH +: COUNT_WIDTH];
                    r_ht[i] <= core_tag[i*EXTRA_WIDTH +: EXTRA_WIDTH];
                end else if (w_drained[i]) begin
                    r_hv[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_bot_dispatch_merge.sv
// tb_bot_dispatch_merge: directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_bot_dispatch_merge;
    localparam int N = 4, DW = 128, EW = 16, CW = 6, DEPTH = 32, THR = 20;
    logic            clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic [EW-1:0]   in_extra = '0;
    logic            ready_for_burst;
    logic [5:0]      fifo_used;
    logic [N-1:0]    core_request = '0, core_start, core_done = '0;
    logic [DW-1:0]   core_data;
    logic [EW-1:0]   core_extra;
    logic [N*CW-1:0] core_count = '0;
    logic [N*EW-1:0] core_tag = '0;
    logic            res_valid, in_overflow, res_overflow;
    logic [CW-1:0]   res_count;
    logic [EW-1:0]   res_extra;

    bot_dispatch_merge dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_extra(in_extra),
        .ready_for_burst(ready_for_burst), .fifo_used(fifo_used), .core_request(core_request),
        .core_start(core_start), .core_data(core_data), .core_extra(core_extra),
        .core_done(core_done), .core_count(core_count), .core_tag(core_tag),
        .res_valid(res_valid), .res_count(res_count), .res_extra(res_extra),
        .in_overflow(in_overflow), .res_overflow(res_overflow)
    );

    always #5 clk = ~clk;

    logic [DW+EW-1:0] q[$];
    int               pend[N];
    int               rr, rrr, n_vec, n_err;
    bit               m_ready, m_inov, m_resov, m_rv;
    bit               hv[N];
    logic [CW-1:0]    hc[N];
    logic [EW-1:0]    ht[N];
    logic [N-1:0]     m_start;
    logic [DW-1:0]    m_data;
    logic [EW-1:0]    m_extra, m_rext;
    logic [CW-1:0]    m_cnt;
    logic [DW-1:0]    bots[4];
    logic [EW-1:0]    tags[4];

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rr = 0; rrr = 0;
        m_ready = 0; m_inov = 0; m_resov = 0; m_rv = 0;
        m_start = '0; m_data = '0; m_extra = '0; m_cnt = '0; m_rext = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; hv[i] = 0; hc[i] = '0; ht[i] = '0;
        end
    endtask

    task automatic model_step();
        int g, d;
        bit r, nr;
        g = -1;
        d = -1;
        nr = q.size() <= THR;
        if (q.size() > 0)
            for (int k = 0; k < N; k++) if (g < 0 && pend[(rr + k) % N] > 0) g = (rr + k) % N;
        m_start = '0;
        if (g >= 0) begin
            {m_data, m_extra} = q.pop_front();
            m_start = N'(1) << g;
            rr = (g + 1) % N;
        end
        if (in_valid) begin
            if (q.size() < DEPTH) q.push_back({in_data, in_extra});
            else m_inov = 1;
        end
        m_ready = nr;
        for (int i = 0; i < N; i++) begin
            r = core_request[i] && pend[i] < 3;
            pend[i] += int'(r) - int'(g == i);
        end
        for (int k = 0; k < N; k++) if (d < 0 && hv[(rrr + k) % N]) d = (rrr + k) % N;
        m_rv = d >= 0;
        if (d >= 0) begin
            m_cnt = hc[d]; m_rext = ht[d]; hv[d] = 0;
            rrr = (d + 1) % N;
        end
        for (int i = 0; i < N; i++) if (core_done[i]) begin
            if (hv[i]) m_resov = 1;
            else begin
                hv[i] = 1; hc[i] = core_count[i*CW +: CW]; ht[i] = core_tag[i*EW +: EW];
            end
        end
    endtask

    task automatic compare();
        chk("fifo_used", fifo_used, q.size());
        chk("ready_for_burst", ready_for_burst, m_ready);
        chk("in_overflow", in_overflow, m_inov);
        chk("core_start", core_start, m_start);
        chk("core_data", core_data, m_data);
        chk("core_extra", core_extra, m_extra);
        chk("res_valid", res_valid, m_rv);
        chk("res_count", res_count, m_cnt);
        chk("res_extra", res_extra, m_rext);
        chk("res_overflow", res_overflow, m_resov);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        in_valid = 0; core_request = '0; core_done = '0;
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        chk("rst_ready", ready_for_burst, 0);
        chk("rst_used", fifo_used, 0);
        chk("rst_start", core_start, 0);
        chk("rst_data", core_data, 0);
        chk("rst_extra", core_extra, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_count", res_count, 0);
        chk("rst_res_extra", res_extra, 0);
        chk("rst_in_ovf", in_overflow, 0);
        chk("rst_res_ovf", res_overflow, 0);
        idle();
        model_reset();
        @(negedge clk);
        rst_n = 1;
        compare();
        cycle();
        chk("ready_after_release", ready_for_burst, 1);
    endtask

    task automatic write_bot(input int j);
        in_valid = 1;
        in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_extra = EW'($urandom());
        if (j < 4) begin bots[j] = in_data; tags[j] = in_extra; end
        cycle();
        idle();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        // Single request to core 2 with three bots buffered
        for (int j = 0; j < 3; j++) write_bot(j);
        core_request = 4'b0100; cycle(); idle();
        chk("r21_used_before", fifo_used, 3);
        cycle();
        chk("r21_start", core_start, 4'b0100);
        chk("r21_data", core_data, bots[0]);
        chk("r21_extra", core_extra, tags[0]);
        chk("r21_used_after", fifo_used, 2);
        // Simultaneous requests on all cores
        do_reset();
        for (int j = 0; j < 4; j++) write_bot(j);
        core_request = 4'b1111; cycle(); idle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("r22_start", core_start, 4'b0001 << k);
            chk("r22_data", core_data, bots[k]);
        end
        cycle();
        chk("r22_start_idle", core_start, 0);
        // Overfill, then drain 12 bots to get back under the threshold
        do_reset();
        for (int j = 0; j < 33; j++) write_bot(j);
        chk("r23_used_full", fifo_used, 32);
        chk("r23_in_ovf", in_overflow, 1);
        chk("r23_ready_low", ready_for_burst, 0);
        for (int j = 0; j < 3; j++) begin core_request = 4'b1111; cycle(); end
        idle();
        for (int j = 0; j < 16; j++) cycle();
        chk("r23_used_20", fifo_used, 20);
        chk("r23_ready_high", ready_for_burst, 1);
        // Two results in the same cycle
        do_reset();
        core_done = 4'b1001;
        core_count = '0; core_count[0 +: CW] = 6'd5; core_count[3*CW +: CW] = 6'd9;
        core_tag = '0; core_tag[0 +: EW] = 16'hA0A0; core_tag[3*EW +: EW] = 16'hB3B3;
        cycle(); idle();
        chk("r24_no_res_yet", res_valid, 0);
        cycle();
        chk("r24_valid0", res_valid, 1);
        chk("r24_count0", res_count, 5);
        chk("r24_tag0", res_extra, 16'hA0A0);
        cycle();
        chk("r24_valid1", res_valid, 1);
        chk("r24_count1", res_count, 9);
        chk("r24_tag1", res_extra, 16'hB3B3);
        cycle();
        chk("r24_idle", res_valid, 0);
        // Back-to-back results on core 1 while core 0 is drained first
        do_reset();
        core_done = 4'b0111;
        core_count = '0; core_count[0 +: CW] = 6'd1; core_count[CW +: CW] = 6'd3; core_count[2*CW +: CW] = 6'd4;
        core_tag = '0; core_tag[EW +: EW] = 16'h1111;
        cycle();
        core_done = 4'b0010; core_count[CW +: CW] = 6'd7; core_tag[EW +: EW] = 16'h7777;
        cycle(); idle();
        chk("r25_res_ovf", res_overflow, 1);
        chk("r25_first_core0", res_count, 1);
        cycle();
        chk("r25_kept_count", res_count, 3);
        chk("r25_kept_tag", res_extra, 16'h1111);
        cycle();
        chk("r25_then_core2", res_count, 4);
        // Randomized traffic with a reset in the middle of a burst
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            in_valid = $urandom_range(0, 99) < 60;
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_extra = EW'($urandom());
            for (int i = 0; i < N; i++) begin
                core_request[i] = $urandom_range(0, 99) < 15;
                core_done[i] = $urandom_range(0, 99) < 25;
            end
            core_count = (N*CW)'($urandom());
            core_tag = {$urandom(), $urandom()};
            if (c == 700) do_reset();
            else cycle();
        end
        idle();
        for (int j = 0; j < 40; j++) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
